// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: round-robin ADC scan sequencer with settle delay, conversion timeout and timestamped sample handshake
module adc_scan_scheduler #(
  parameter int NUM_CHANNELS    = 16,
  parameter int CHANNEL_WIDTH   = $clog2(NUM_CHANNELS),
  parameter int DATA_WIDTH      = 12,
  parameter int TIMESTAMP_WIDTH = 32,
  parameter int SETTLE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_CHANNELS-1:0]    channel_mask,
  input  logic [31:0]                scan_period,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  output logic [CHANNEL_WIDTH-1:0]   adc_channel,
  output logic                       adc_start,
  input  logic                       adc_done,
  input  logic [DATA_WIDTH-1:0]      adc_data,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic [CHANNEL_WIDTH-1:0]   sample_channel,
  output logic [DATA_WIDTH-1:0]      sample_data,
  output logic [TIMESTAMP_WIDTH-1:0] sample_timestamp,
  output logic                       scan_active,
  output logic                       scan_done,
  output logic [15:0]                scan_count,
  output logic [15:0]                timeout_count,
  output logic [15:0]                overrun_count
);
  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, CONVERT, OUTPUT, END_SCAN, WAIT_PERIOD} state_t;
  localparam int PW = CHANNEL_WIDTH + 1;
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, state_n;
  logic [NUM_CHANNELS-1:0] mask_l;
  logic [PW-1:0] ptr;
  logic [31:0] elapsed;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] wait_cnt;
  logic abort_l, found, period_hit, overrun, timeout, last_ch, aborting, scan_start, drop;
  logic [CHANNEL_WIDTH-1:0] sel_ch;
  assign period_hit = {1'b0, elapsed} + 33'd1 >= {1'b0, scan_period};
  assign overrun    = scan_period != 32'd0 && elapsed >= scan_period;
  assign timeout    = wait_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign last_ch    = adc_channel == CHANNEL_WIDTH'(NUM_CHANNELS - 1);
  assign aborting   = abort_l | ~enable;
  assign drop       = state == CONVERT && timeout && !adc_done;
  assign scan_start = state_n == SELECT && (state == IDLE || state == WAIT_PERIOD);
  // lowest enabled channel at or above the scan pointer
  always_comb begin
    found = 1'b0;
    sel_ch = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (mask_l[i] && PW'(i) >= ptr) begin
        found = 1'b1;
        sel_ch = CHANNEL_WIDTH'(i);
      end
  end
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        state_n = enable && channel_mask != '0 ? SELECT : IDLE;
      SELECT:      state_n = !enable ? IDLE : !found ? END_SCAN : SETTLE_CYCLES == 0 ? CONVERT : SETTLE;
      SETTLE:      state_n = !enable ? IDLE : settle_cnt == SW'(SETTLE_CYCLES - 1) ? CONVERT : SETTLE;
      CONVERT:     state_n = !(adc_done || timeout) ? CONVERT : aborting ? IDLE : adc_done ? OUTPUT : SELECT;
      OUTPUT:      state_n = !sample_ready ? OUTPUT : !enable ? IDLE : last_ch ? END_SCAN : SELECT;
      END_SCAN:    state_n = enable ? WAIT_PERIOD : IDLE;
      WAIT_PERIOD: state_n = !enable ? IDLE : !period_hit ? WAIT_PERIOD : channel_mask != '0 ? SELECT : IDLE;
      default:     state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // scan bookkeeping: mask latch, channel pointer, period timer, settle/wait counters, abort flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mask_l <= '0;
      ptr <= '0;
      elapsed <= '0;
      settle_cnt <= '0;
      wait_cnt <= '0;
      abort_l <= 1'b0;
    end else begin
      if (scan_start) begin
        mask_l <= channel_mask;
        ptr <= '0;
      end else if (drop || (state == OUTPUT && sample_ready)) ptr <= PW'(adc_channel) + PW'(1);
      elapsed <= scan_start ? '0 : elapsed + 32'(elapsed != '1);
      settle_cnt <= state == SETTLE ? settle_cnt + 1'b1 : '0;
      wait_cnt <= state == CONVERT ? wait_cnt + 1'b1 : '0;
      abort_l <= state == CONVERT && aborting;
    end
  // registered outputs: ADC control, sample payload and handshake, scan status and saturating counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      adc_channel <= '0;
      adc_start <= 1'b0;
      sample_valid <= 1'b0;
      sample_channel <= '0;
      sample_data <= '0;
      sample_timestamp <= '0;
      scan_active <= 1'b0;
      scan_done <= 1'b0;
      scan_count <= '0;
      timeout_count <= '0;
      overrun_count <= '0;
    end else begin
      adc_start <= state != CONVERT && state_n == CONVERT;
      if (state == SELECT && found) adc_channel <= sel_ch;
      if (adc_start) sample_timestamp <= timestamp;
      if (state == CONVERT && adc_done && !aborting) begin
        sample_data <= adc_data;
        sample_channel <= adc_channel;
      end
      sample_valid <= state_n == OUTPUT;
      scan_active <= state_n != IDLE;
      scan_done <= state_n == END_SCAN;
      if (state == END_SCAN) scan_count <= scan_count + 16'(scan_count != 16'hFFFF);
      if (drop) timeout_count <= timeout_count + 16'(timeout_count != 16'hFFFF);
      if (state == WAIT_PERIOD && enable && period_hit && overrun) overrun_count <= overrun_count + 16'(overrun_count != 16'hFFFF);
    end
endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Sequences the shared multi-channel ADC through round-robin scans of an enabled-channel mask. It issues one conversion at a time with a settle delay, enforces a conversion timeout, and delivers timestamped samples to the FIFO path over a valid/ready handshake. Its `adc_start`/`adc_done`/`adc_channel` and sample outputs also drive the ADC and data-flow inputs of the performance monitor.

## Interface
- `NUM_CHANNELS`, 16: number of ADC channels.
- `CHANNEL_WIDTH`, `$clog2(NUM_CHANNELS)`: channel index width.
- `DATA_WIDTH`, 12: ADC result width.
- `TIMESTAMP_WIDTH`, 32: timestamp width.
- `SETTLE_CYCLES`, 4: mux settle cycles before each conversion; 0 is legal.
- `TIMEOUT_CYCLES`, 100000: maximum cycles to wait for `adc_done` (1 ms at 100 MHz).

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: scanning enabled.
- `channel_mask`  in  `NUM_CHANNELS`: bit i=1 includes channel i.
- `scan_period`  in  32: cycles from one scan start to the next; 0 means back-to-back.
- `timestamp`  in  `TIMESTAMP_WIDTH`: free-running system time.
- `adc_channel`  out  `CHANNEL_WIDTH`: mux select to the ADC.
- `adc_start`  out  1: one-cycle conversion start pulse.
- `adc_done`  in  1: conversion complete, valid for one cycle.
- `adc_data`  in  `DATA_WIDTH`: result, valid with `adc_done`.
- `sample_valid`  out  1: sample offered.
- `sample_ready`  in  1: downstream accepts; this is the inverse of FIFO full.
- `sample_channel`  out  `CHANNEL_WIDTH`, `sample_data`  out  `DATA_WIDTH`, `sample_timestamp`  out  `TIMESTAMP_WIDTH`: sample payload.
- `scan_active`  out  1: high in any state other than IDLE.
- `scan_done`  out  1: one-cycle pulse at the end of each scan.
- `scan_count`  out  16, `timeout_count`  out  16, `overrun_count`  out  16: saturating counters.

## Operation
- States: IDLE, SELECT, SETTLE, CONVERT, OUTPUT, END_SCAN, WAIT_PERIOD.
- **IDLE:**
  - Go to SELECT when `enable`=1 and `channel_mask`≠0. This cycle is the scan start.
  - At scan start, latch `channel_mask` into `mask_l`, set `ptr`=0, and clear `elapsed`.
  - Mask changes during a scan take effect at the next scan start.
- **SELECT:**
  - Find the lowest channel c ≥ `ptr` with `mask_l[c]`=1.
  - If found, register `adc_channel`=c and go to SETTLE, or directly to CONVERT when `SETTLE_CYCLES`=0.
  - If none is found, go to END_SCAN.
- **SETTLE:** hold `adc_channel` for exactly `SETTLE_CYCLES` cycles, then go to CONVERT.
- **CONVERT:**
  - `adc_start`=1 in the first CONVERT cycle only.
  - Capture `timestamp` in that same cycle as `sample_timestamp`.
  - The wait counter starts at 0 on entry.
  - On `adc_done`: capture `adc_data` and go to OUTPUT.
  - On timeout (wait counter = `TIMEOUT_CYCLES`-1 with no `adc_done`): increment `timeout_count`, drop the channel, set `ptr`=c+1, and go to SELECT.
  - If `adc_done` and timeout occur in the same cycle, `adc_done` wins.
- **OUTPUT:**
  - Hold `sample_valid`=1 with a stable payload until `sample_ready`=1.
  - On the handshake, set `ptr`=c+1 and go to SELECT. If c = `NUM_CHANNELS`-1, go to END_SCAN instead.
- **END_SCAN:**
  - `scan_done`=1 and `scan_count`++.
  - Go to IDLE if `enable`=0, otherwise go to WAIT_PERIOD.
- **WAIT_PERIOD:**
  - Start the next scan (same actions as the IDLE exit) in the first cycle where `elapsed`+1 ≥ `scan_period`.
  - If `elapsed` ≥ `scan_period` on entry and `scan_period`≠0, `overrun_count`++ and the next scan starts immediately.
  - `enable`=0 → IDLE.
  - A latched mask of 0 at scan start → IDLE.
- **`enable` falling mid-scan:**
  - SELECT, SETTLE, or WAIT_PERIOD → IDLE next cycle.
  - CONVERT → finish on `adc_done` or timeout, discard the result, then IDLE.
  - OUTPUT → complete the handshake, then IDLE.
- `adc_done` outside CONVERT is ignored.
- All counters saturate at `16'hFFFF`; `elapsed` saturates at `32'hFFFFFFFF`.

## Timing
- Reset values:
  - State IDLE.
  - `adc_start`, `sample_valid`, `scan_active`, `scan_done` = 0.
  - `adc_channel`, `sample_channel`, `sample_data`, `sample_timestamp` = 0.
  - All counters = 0.
- All outputs are registered. `sample_valid` rises the cycle after `adc_done` is sampled.
- With `SETTLE_CYCLES`=S, `adc_start` occurs S+2 cycles after the scan start cycle (IDLE exit).
- `sample_valid` does not drop without a handshake; the payload does not change while `sample_valid`=1.
- `elapsed` counts clocks since the scan start cycle, which is elapsed=0.
- Reset asserted mid-operation returns all state and outputs to their reset values immediately (asynchronous).

## Test plan
- **Basic scan:** mask=`16'h0005`, S=4, ADC responds 10 cycles after start, `sample_ready`=1 → samples for channel 0 then channel 2; `adc_start` 6 cycles after scan start; one `scan_done`; `scan_count`=1.
- **Backpressure:** hold `sample_ready`=0 for 20 cycles in OUTPUT → `sample_valid` held with a constant payload; no new `adc_start`; scan resumes after ready.
- **Timeout:** mask=`16'h0003`, channel 0 never sends done, `TIMEOUT_CYCLES`=50 → `timeout_count`=1; channel 0 sample absent; channel 1 start exactly 50 cycles after channel 0 start plus SELECT/SETTLE overhead; done arriving in the same cycle as timeout produces a sample and no timeout.
- **Period and overrun:**
  - `scan_period`=200 with a short scan → scan starts exactly 200 cycles apart.
  - `scan_period`=10 with a scan longer than 10 cycles → `overrun_count` increments every scan; scans run back-to-back.
- **Abort and mask change:**
  - Drop `enable` in CONVERT → no `sample_valid`; IDLE after done.
  - Change mask mid-scan → current scan uses the old mask; next scan uses the new mask.
  - Assert `rst_n` mid-OUTPUT → all outputs 0 immediately.
